boot_sequencer: RTL

Front-panel boot controller that sits directly upstream and downstream of the RIM loader.
- Upstream: debounces the BOOT switch, issues the loader's one-cycle `start` pulse and halts the CPU while loading runs.
- Downstream: consumes the loader's address/data/we/loading and muxes them onto the single memory write port, counts the 16 words written, then forces PC to the RIM entry point and releases the CPU.

---
 rtl/pdp8_pkg.sv | 20 ++
 rtl/debounce.sv | 43 ++++
 rtl/boot_sequencer.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pdp8_pkg.sv
// Shared PDP-8 front-panel types, RIM loader constants and boot states.
// Declarations only: no latency, no flow control.
package pdp8_pkg;

  typedef logic [11:0] word12_t;

  localparam word12_t     RIM_START = 12'o7756;
  localparam int unsigned RIM_LEN   = 16;

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    WAIT,
    LOAD,
    SETPC,
    RELEASE,
    ERROR
  } boot_state_t;

endpackage

// File: rtl/debounce.sv
// Front-panel switch debouncer: 2-flop synchroniser plus stability counter.
// Latency: 2 sync clocks + 2**DEBOUNCE_BITS stable clocks; no backpressure.
module debounce #(
  parameter int unsigned DEBOUNCE_BITS = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic [1:0]               r_sync;
  logic [DEBOUNCE_BITS-1:0] r_cnt;
  logic                     r_level;
  logic                     r_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], raw};
      r_rise <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == '1) begin
        // rise is registered alongside the level so it is exactly one cycle wide
        r_cnt   <= '0;
        r_level <= ~r_level;
        r_rise  <= ~r_level;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign rise  = r_rise;

endmodule

// File: rtl/boot_sequencer.sv
// Boot controller: debounced BOOT starts the RIM loader, muxes its writes, then loads PC.
// Latency: 1 clk debounced edge->ldr_start, loading fall->pc_load, pc_load->release; no backpressure.
module boot_sequencer
  import pdp8_pkg::*;
#(
  parameter int unsigned DEBOUNCE_BITS = 16,
  parameter word12_t     START_ADDR    = RIM_START,
  parameter int unsigned RIM_WORDS     = RIM_LEN,
  parameter int unsigned ARM_TIMEOUT   = 8
) (
  input  logic    clk,
  input  logic    reset_n,
  input  logic    btn_boot,
  output logic    ldr_start,
  input  logic    ldr_loading,
  input  word12_t ldr_address,
  input  word12_t ldr_data,
  input  logic    ldr_we,
  input  word12_t cpu_address,
  input  word12_t cpu_data,
  input  logic    cpu_we,
  output word12_t mem_address,
  output word12_t mem_data,
  output logic    mem_we,
  output logic    cpu_halt,
  output logic    pc_load,
  output word12_t pc_value,
  output logic    busy,
  output logic    boot_error
);

  localparam int unsigned TMR_W = $clog2(ARM_TIMEOUT + 1);

  boot_state_t      r_state;
  boot_state_t      w_state_nxt;
  logic [TMR_W-1:0] r_timer;
  logic [4:0]       r_words;
  logic             w_level;
  logic             w_rise;
  logic             w_req;

  debounce #(
    .DEBOUNCE_BITS (DEBOUNCE_BITS)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (btn_boot),
    .level   (w_level),
    .rise    (w_rise)
  );

  assign w_req = w_rise & w_level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_words <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == WAIT) r_timer <= r_timer + 1'b1;
      else                 r_timer <= '0;
      // word count saturates so a runaway loader cannot alias back to RIM_WORDS
      if (r_state == ARM) begin
        r_words <= '0;
      end else if (r_state == LOAD && ldr_loading && ldr_we && r_words != '1) begin
        r_words <= r_words + 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    ldr_start   = 1'b0;
    cpu_halt    = 1'b0;
    busy        = 1'b0;
    pc_load     = 1'b0;
    pc_value    = '0;
    boot_error  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) w_state_nxt = ARM;
      end
      ARM: begin
        ldr_start   = 1'b1;
        cpu_halt    = 1'b1;
        busy        = 1'b1;
        w_state_nxt = WAIT;
      end
      WAIT: begin
        cpu_halt = 1'b1;
        busy     = 1'b1;
        if (ldr_loading)                                w_state_nxt = LOAD;
        else if (r_timer == TMR_W'(ARM_TIMEOUT - 1))   w_state_nxt = ERROR;
      end
      LOAD: begin
        cpu_halt = 1'b1;
        busy     = 1'b1;
        if (!ldr_loading) w_state_nxt = (r_words == 5'(RIM_WORDS)) ? SETPC : ERROR;
      end
      SETPC: begin
        pc_load     = 1'b1;
        pc_value    = START_ADDR;
        cpu_halt    = 1'b1;
        busy        = 1'b1;
        w_state_nxt = RELEASE;
      end
      RELEASE: begin
        w_state_nxt = IDLE;
      end
      ERROR: begin
        boot_error = 1'b1;
        cpu_halt   = 1'b1;
        if (w_req) w_state_nxt = ARM;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Halted states coincide with the states that must block CPU writes.
  always_comb begin
    if (ldr_loading) begin
      mem_address = ldr_address;
      mem_data    = ldr_data;
      mem_we      = ldr_we;
    end else begin
      mem_address = cpu_address;
      mem_data    = cpu_data;
      mem_we      = cpu_we & ~cpu_halt;
    end
  end

endmodule
